// File: rtl/rgb_packer_pkg.sv
// Constants shared with the ISP stages: sample width, colour tag width and tag codes,
// plus the packer's assembler state encoding.
package rgb_packer_pkg;

  localparam int COLOR_DEPTH   = 8;
  localparam int COLOR_BIT_CNT = 2;

  localparam logic [COLOR_BIT_CNT-1:0] RED   = 2'd0;
  localparam logic [COLOR_BIT_CNT-1:0] GREEN = 2'd1;
  localparam logic [COLOR_BIT_CNT-1:0] BLUE  = 2'd2;
  localparam logic [COLOR_BIT_CNT-1:0] VOID  = 2'd3;

  localparam logic [1:0] EXP_R = 2'd0;
  localparam logic [1:0] EXP_G = 2'd1;
  localparam logic [1:0] EXP_B = 2'd2;

endpackage

// File: rtl/rgb_fifo.sv
// Small synchronous FIFO whose head entry is held in a register, so the output is stable
// until popped and keeps its last value while the FIFO is empty.
module rgb_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok, push_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && !push_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    remain   = count_q - (AW+1)'(pop_ok);
    head_d   = head_q;
    if (remain != '0) begin
      head_d = mem[rd_ptr_d];
    end else if (push_ok) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_data = head_q;

endmodule

// File: rtl/rgb_packer.sv
// Packs the serialized R/G/B sample stream into {R,G,B} words, buffers them and hands
// them out over valid/ready with line/frame markers, a per-frame word count and error flags.
module rgb_packer
  import rgb_packer_pkg::*;
#(
  parameter int COLOR_DEPTH = rgb_packer_pkg::COLOR_DEPTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COLOR_DEPTH-1:0]   pixel_in,
  input  logic                     valid_in,
  input  logic [COLOR_BIT_CNT-1:0] color_in,
  input  logic                     last_col_in,
  input  logic                     last_pic_in,
  output logic [3*COLOR_DEPTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last_col,
  output logic                     out_last_pic,
  output logic [CNT_WIDTH-1:0]     word_cnt,
  output logic                     frame_done,
  output logic                     seq_err,
  output logic                     overflow
);

  localparam int WW = 3*COLOR_DEPTH + 2;

  logic [1:0]             state_q, state_d;
  logic [COLOR_DEPTH-1:0] r_q, r_d;
  logic [COLOR_DEPTH-1:0] g_q, g_d;
  logic                   seq_err_q, seq_err_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;

  logic          push, pop;
  logic [WW-1:0] push_word, head_word;
  logic          fifo_full, fifo_empty, fifo_dropped;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    g_d       = g_q;
    seq_err_d = 1'b0;
    push      = 1'b0;
    if (valid_in && (color_in != VOID)) begin
      case (state_q)
        EXP_R: begin
          if (color_in == RED) begin
            r_d     = pixel_in;
            state_d = EXP_G;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        EXP_G: begin
          if (color_in == GREEN) begin
            g_d     = pixel_in;
            state_d = EXP_B;
          end else if (color_in == RED) begin
            seq_err_d = 1'b1;
            r_d       = pixel_in;
          end else begin
            seq_err_d = 1'b1;
            state_d   = EXP_R;
          end
        end
        EXP_B: begin
          if (color_in == BLUE) begin
            push    = 1'b1;
            state_d = EXP_R;
          end else if (color_in == RED) begin
            seq_err_d = 1'b1;
            r_d       = pixel_in;
            state_d   = EXP_G;
          end else begin
            seq_err_d = 1'b1;
            state_d   = EXP_R;
          end
        end
        default: state_d = EXP_R;
      endcase
    end
  end

  assign push_word = {last_pic_in, last_col_in, r_q, g_q, pixel_in};

  rgb_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign out_last_pic = head_word[WW-1];
  assign out_last_col = head_word[WW-2];
  assign out_data     = head_word[3*COLOR_DEPTH-1:0];

  // The frame-ending pop restarts the count rather than incrementing it.
  always_comb begin
    frame_done_d = pop && out_last_pic;
    overflow_d   = overflow_q || fifo_dropped;
    word_cnt_d   = word_cnt_q;
    if (pop) begin
      word_cnt_d = out_last_pic ? '0 : word_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EXP_R;
      r_q          <= '0;
      g_q          <= '0;
      seq_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      g_q          <= g_d;
      seq_err_q    <= seq_err_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign seq_err    = seq_err_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_rgb_packer.sv
// Randomized and directed stimulus for rgb_packer, checked every cycle against a
// queue-based model of triplet assembly, FIFO occupancy and frame counting.
module tb_rgb_packer;

  localparam int CD    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CD-1:0] pixel_in;
  logic          valid_in;
  logic [1:0]    color_in;
  logic          last_col_in, last_pic_in;
  logic [3*CD-1:0] out_data;
  logic          out_valid, out_ready, out_last_col, out_last_pic;
  logic [CW-1:0] word_cnt;
  logic          frame_done, seq_err, overflow;

  rgb_packer #(.COLOR_DEPTH(CD), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .valid_in     (valid_in),
    .color_in     (color_in),
    .last_col_in  (last_col_in),
    .last_pic_in  (last_pic_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last_col (out_last_col),
    .out_last_pic (out_last_pic),
    .word_cnt     (word_cnt),
    .frame_done   (frame_done),
    .seq_err      (seq_err),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: samples of the triplet in progress and the words awaiting pop.
  logic [CD-1:0]   partial[$];
  logic [3*CD+1:0] mq[$];
  logic [3*CD+1:0] last_head = '0;
  int              m_cnt = 0;
  logic            m_seq_err = 0, m_frame_done = 0, m_overflow = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    partial.delete();
    mq.delete();
    last_head    = '0;
    m_cnt        = 0;
    m_seq_err    = 0;
    m_frame_done = 0;
    m_overflow   = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, ".head"}, 32'({out_last_pic, out_last_col, out_data}),
          32'((mq.size() > 0) ? mq[0] : last_head));
    check({tag, ".cnt"}, 32'(word_cnt), 32'(m_cnt));
    check({tag, ".seq_err"}, 32'(seq_err), 32'(m_seq_err));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(m_frame_done));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_overflow));
  endtask

  // One clock: apply a beat, advance the model by the colour-order rules, compare.
  task automatic step(input string tag, input logic [CD-1:0] px, input logic v,
                      input logic [1:0] c, input logic lc, input logic lp, input logic rdy);
    logic            pop;
    logic [3*CD+1:0] popped;
    pixel_in = px; valid_in = v; color_in = c;
    last_col_in = lc; last_pic_in = lp; out_ready = rdy;
    @(posedge clk);
    #1;
    pop          = (mq.size() > 0) && rdy;
    m_seq_err    = 0;
    m_frame_done = 0;
    if (pop) begin
      popped = mq.pop_front();
      if (popped[3*CD+1]) begin
        m_cnt        = 0;
        m_frame_done = 1;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    if (v && c != 2'd3) begin
      if (int'(c) == partial.size()) begin
        partial.push_back(px);
        if (partial.size() == 3) begin
          if (mq.size() < DEPTH) mq.push_back({lp, lc, partial[0], partial[1], partial[2]});
          else m_overflow = 1;
          partial.delete();
        end
      end else begin
        m_seq_err = 1;
        partial.delete();
        if (c == 2'd0) partial.push_back(px);
      end
    end
    if (mq.size() > 0) last_head = mq[0];
    compare_all(tag);
  endtask

  task automatic triplet(input string tag, input logic [CD-1:0] r, input logic [CD-1:0] g,
                         input logic [CD-1:0] b, input logic lc, input logic lp, input logic rdy);
    step(tag, r, 1'b1, 2'd0, 1'b0, 1'b0, rdy);
    step(tag, g, 1'b1, 2'd1, 1'b0, 1'b0, rdy);
    step(tag, b, 1'b1, 2'd2, lc, lp, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".data"}, 32'({out_last_pic, out_last_col, out_data}), 32'd0);
    check({tag, ".cnt"}, 32'(word_cnt), 32'd0);
    check({tag, ".flags"}, 32'({frame_done, seq_err, overflow}), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs({tag, ".async"});
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs({tag, ".held"});
    model_reset();
    rst = 1'b0;
  endtask

  logic [1:0] nxt, c;
  logic       v, rdy;

  initial begin
    rst = 1'b1;
    pixel_in = '0; valid_in = 1'b0; color_in = 2'd0;
    last_col_in = 1'b0; last_pic_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single triplet with the consumer ready.
    triplet("t1", 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 1'b1);
    check("t1.word", 32'(out_data), 32'h112233);
    step("t1.pop", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("t1.wc", 32'(word_cnt), 32'd1);
    step("t1.idle", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // 4x1 frame, markers on the final BLUE beat.
    for (int i = 0; i < 4; i++)
      triplet("frame", 8'(i), 8'(i + 16), 8'(i + 32), 1'(i == 3), 1'(i == 3), 1'b1);
    repeat (3) step("frame.drain", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Order violations: R, B, R, G, B.
    step("seq", 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    step("seq", 8'hB0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    step("seq", 8'hA1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    step("seq", 8'hC1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    step("seq", 8'hD1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    check("seq.word", 32'(out_data), 32'hA1C1D1);
    step("seq.pop", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // VOID beats and idle gaps inside a triplet.
    step("void", 8'h5A, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    step("void", 8'hFF, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    step("void", 8'hEE, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    step("void", 8'h6B, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    step("void", 8'hDD, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step("void", 8'hCC, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    step("void", 8'h7C, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    check("void.word", 32'(out_data), 32'h5A6B7C);
    step("void.pop", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Overflow: FIFO_DEPTH+1 triplets against a stalled consumer, then drain.
    for (int i = 0; i <= DEPTH; i++)
      triplet("ovf", 8'(8'h40 + i), 8'(8'h50 + i), 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    check("ovf.sticky", 32'(overflow), 32'd1);
    repeat (DEPTH + 2) step("ovf.drain", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("ovf.after_drain", 32'(overflow), 32'd1);

    // Reset with a partial triplet pending.
    step("rst_mid", 8'h91, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    step("rst_mid", 8'h92, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    do_reset("rst_mid");
    step("rst_mid.blue", 8'h93, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    triplet("rst_mid.new", 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    check("rst_mid.word", 32'(out_data), 32'h010203);
    step("rst_mid.pop", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Randomized stream, mostly in order, with occasional rogue tags and stalls.
    nxt = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      c   = ($urandom_range(0, 9) < 8) ? nxt : 2'($urandom_range(0, 3));
      v   = ($urandom_range(0, 5) != 0);
      rdy = (i < 600) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
      if (v && c == nxt) nxt = (nxt == 2'd2) ? 2'd0 : nxt + 2'd1;
      step("rand", 8'($urandom), v, c, 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 7) == 0), rdy);
    end
    repeat (DEPTH + 2) step("rand.drain", 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
